// File: rtl/ser_pkg.sv
// Shared definitions for the serializer / deserializer pair.
// Word width default, mod encoding (WIDTH encoded as 0), word/mod types,
// the receive FSM state type and a mod-to-bit-count helper.
package ser_pkg;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned MOD_W = $clog2(WIDTH);

  typedef logic [WIDTH-1:0] word_t;
  typedef logic [MOD_W-1:0] mod_t;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } deser_state_t;

  // A mod of 0 stands for a full WIDTH-bit word.
  function automatic int unsigned mod_to_bits(input mod_t m);
    if (m == '0) begin
      return WIDTH;
    end
    return 32'(m);
  endfunction

endpackage

// File: rtl/deserializer.sv
// Purpose : rebuilds left-aligned parallel words from an MSB-first serial stream;
//           a frame is a run of valid bits, closed by a valid gap or by WIDTH bits.
// Latency : val/drop pulse one cycle after the edge that sampled the frame end.
// Backpressure: none; every val/drop pulse must be taken by the downstream stage.
// Ports:
//   clk_i, srst_i           clock, synchronous active-high reset
//   data_i, data_val_i      serial bit and its valid
//   deser_data_o            reassembled word, first bit at [WIDTH-1], unreceived bits 0
//   deser_mod_o             bits in the frame, WIDTH encoded as 0 (held until next emit)
//   deser_data_val_o        one-cycle pulse, word/mod valid
//   drop_o                  one-cycle pulse, runt frame (< MIN_LEN bits) discarded
//   busy_o                  frame partially collected
module deserializer
  import ser_pkg::*;
#(
  parameter int unsigned WIDTH   = ser_pkg::WIDTH,
  parameter int unsigned MIN_LEN = 3
) (
  input  logic                     clk_i,
  input  logic                     srst_i,
  input  logic                     data_i,
  input  logic                     data_val_i,
  output logic [WIDTH-1:0]         deser_data_o,
  output logic [$clog2(WIDTH)-1:0] deser_mod_o,
  output logic                     deser_data_val_o,
  output logic                     drop_o,
  output logic                     busy_o
);

  localparam int unsigned    CW      = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST    = CW'(WIDTH - 1);
  localparam logic [CW-1:0]  MIN_CNT = CW'(MIN_LEN);

  deser_state_t     state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] shreg_ins;

  // Current shift register with the incoming bit dropped into the next free slot.
  // Slots are filled from the top down, so lower bits stay 0 until written.
  always_comb begin
    shreg_ins                = shreg;
    shreg_ins[LAST - count]  = data_i;
  end

  // count never holds WIDTH: the WIDTH-th bit emits straight away and clears it.
  assign busy_o = (count != '0);

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state            <= ST_IDLE;
      shreg            <= '0;
      count            <= '0;
      deser_data_o     <= '0;
      deser_mod_o      <= '0;
      deser_data_val_o <= 1'b0;
      drop_o           <= 1'b0;
    end else begin
      deser_data_val_o <= 1'b0;
      drop_o           <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (data_val_i) begin
            shreg <= {data_i, {(WIDTH-1){1'b0}}};
            count <= CW'(1);
            state <= ST_COLLECT;
          end
        end

        ST_COLLECT: begin
          if (data_val_i) begin
            if (count == LAST) begin
              // Full word: emit including this bit, ready for a new frame next cycle.
              deser_data_o     <= shreg_ins;
              deser_mod_o      <= '0;
              deser_data_val_o <= 1'b1;
              shreg            <= '0;
              count            <= '0;
              state            <= ST_IDLE;
            end else begin
              shreg <= shreg_ins;
              count <= count + CW'(1);
            end
          end else begin
            // Valid gap closes the frame; runts are dropped and leave the
            // last emitted word/mod untouched on the outputs.
            if (count >= MIN_CNT) begin
              deser_data_o     <= shreg;
              deser_mod_o      <= count;
              deser_data_val_o <= 1'b1;
            end else begin
              drop_o <= 1'b1;
            end
            shreg <= '0;
            count <= '0;
            state <= ST_IDLE;
          end
        end

        default: begin
          state <= ST_IDLE;
          shreg <= '0;
          count <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_deserializer.sv
module tb_deserializer;
  import ser_pkg::*;

  logic        clk = 1'b0;
  logic        srst_i = 1'b1;
  logic        data_i = 1'b0;
  logic        data_val_i = 1'b0;
  logic [15:0] deser_data_o;
  logic [3:0]  deser_mod_o;
  logic        deser_data_val_o;
  logic        drop_o;
  logic        busy_o;

  always #5 clk = ~clk;

  deserializer #(.WIDTH(16), .MIN_LEN(3)) dut (
    .clk_i           (clk),
    .srst_i          (srst_i),
    .data_i          (data_i),
    .data_val_i      (data_val_i),
    .deser_data_o    (deser_data_o),
    .deser_mod_o     (deser_mod_o),
    .deser_data_val_o(deser_data_val_o),
    .drop_o          (drop_o),
    .busy_o          (busy_o)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // One expected pulse per frame: word/mod or drop, and the cycle it must appear.
  typedef struct {
    logic [15:0] word;
    logic [3:0]  mod;
    bit          drop;
    int          at;
  } exp_t;
  exp_t q[$];

  bit          chk_en = 0;
  bit          busy_d = 0;
  bit          busy_q = 0;
  logic [15:0] last_word = '0;
  logic [3:0]  last_mod  = '0;
  int          last_val_cyc = 0;
  int          prev_val_cyc = 0;

  always @(posedge clk) busy_q <= busy_d;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Per-cycle compare against the frame-level expectation queue.
  always @(negedge clk) begin
    if (chk_en) begin
      exp_t e;
      check("busy", {31'd0, busy_o}, {31'd0, busy_q});
      if (deser_data_val_o || drop_o) begin
        if (q.size() == 0) begin
          check("unexpected_pulse", {30'd0, deser_data_val_o, drop_o}, 32'd0);
        end else begin
          e = q.pop_front();
          check("pulse_kind", {30'd0, deser_data_val_o, drop_o}, e.drop ? 32'd1 : 32'd2);
          check("pulse_cycle", cyc, e.at);
          if (!e.drop) begin
            check("word", {16'd0, deser_data_o}, {16'd0, e.word});
            check("mod", {28'd0, deser_mod_o}, {28'd0, e.mod});
            last_word    = e.word;
            last_mod     = e.mod;
            prev_val_cyc = last_val_cyc;
            last_val_cyc = cyc;
          end else begin
            check("hold_word", {16'd0, deser_data_o}, {16'd0, last_word});
            check("hold_mod", {28'd0, deser_mod_o}, {28'd0, last_mod});
          end
        end
      end else if (q.size() > 0 && q[0].at < cyc) begin
        e = q.pop_front();
        check("missed_pulse", cyc, e.at);
      end
    end
  end

  // Inputs change 2 time units after a rising edge and are sampled at the next one.
  task automatic drive(input logic b, input logic v, input logic r, input bit bz);
    @(posedge clk);
    #2;
    data_i     = b;
    data_val_i = v;
    srst_i     = r;
    busy_d     = bz;
    if (r) begin
      last_word = '0;
      last_mod  = '0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Sends the top len bits of word MSB-first, then gap idle cycles (gap >= 1 if len < 16).
  task automatic send_frame(input logic [15:0] word, input int len, input int gap);
    logic [15:0] mask;
    logic [15:0] exp_word;
    exp_t        e;
    mask     = (len >= 16) ? 16'hFFFF : ~(16'hFFFF >> len);
    exp_word = word & mask;
    for (int i = 0; i < len; i++) begin
      drive(word[15-i], 1'b1, 1'b0, (i + 1) != 16);
      if (i == 15) begin
        e.word = exp_word; e.mod = 4'd0; e.drop = 0; e.at = cyc + 1;
        q.push_back(e);
      end
    end
    for (int g = 0; g < gap; g++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      if (g == 0 && len < 16) begin
        e.word = exp_word; e.mod = 4'(len); e.drop = (len < 3); e.at = cyc + 1;
        q.push_back(e);
      end
    end
  endtask

  initial begin
    int m;
    int len;
    int gap;
    logic [15:0] w;

    drive(1'b1, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("reset_outputs", {11'd0, deser_data_o, deser_mod_o, deser_data_val_o, drop_o, busy_o}, 32'd0);
    chk_en = 1;

    // Full 16-bit frame.
    send_frame(16'hA5C3, 16, 3);
    check("lit_a5c3_word", {16'd0, deser_data_o}, 32'h0000A5C3);
    check("lit_a5c3_mod", {28'd0, deser_mod_o}, 32'd0);

    // 5-bit frame 1,0,1,1,0.
    send_frame(16'hB000, 5, 3);
    check("lit_b000_word", {16'd0, deser_data_o}, 32'h0000B000);
    check("lit_b000_mod", {28'd0, deser_mod_o}, 32'd5);

    // Runt frame of 2 bits: drop, outputs hold.
    send_frame(16'hC000, 2, 3);
    check("lit_drop_hold_word", {16'd0, deser_data_o}, 32'h0000B000);
    check("lit_drop_hold_mod", {28'd0, deser_mod_o}, 32'd5);

    // Back-to-back full frames, no gap.
    send_frame(16'hFFFF, 16, 0);
    send_frame(16'h0001, 16, 3);
    check("lit_b2b_word", {16'd0, deser_data_o}, 32'h00000001);
    check("lit_b2b_spacing", last_val_cyc - prev_val_cyc, 32'd16);

    // Reset after 7 of 12 bits; a valid bit in the reset cycle is ignored.
    w = 16'h1230;
    for (int i = 0; i < 7; i++) drive(w[15-i], 1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("lit_srst_word", {16'd0, deser_data_o}, 32'd0);
    check("lit_srst_busy", {31'd0, busy_o}, 32'd0);
    send_frame(16'h1230, 12, 2);
    check("lit_123_word", {16'd0, deser_data_o}, 32'h00001230);
    check("lit_123_mod", {28'd0, deser_mod_o}, 32'd12);

    // Serializer-style random traffic, every mod value including runts.
    for (int n = 0; n < 300; n++) begin
      m   = $urandom_range(0, 15);
      len = int'(mod_to_bits(4'(m)));
      w   = 16'($urandom);
      gap = (len == 16) ? $urandom_range(0, 2) : $urandom_range(1, 3);
      send_frame(w, len, gap);
    end

    idle(5);
    check("queue_drained", q.size(), 32'd0);
    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/deserializer.md
Name: deserializer

Overview:
- Receive-side counterpart of the serializer. Consumes its serial stream (ser_data_o / ser_data_val_o) and rebuilds parallel words of variable length.
- Frames are MSB-first runs of consecutive valid bits, 1 to WIDTH bits long. A frame ends when data_val_i drops or when WIDTH bits have been collected.
- Emits one left-aligned word plus a bit count per frame, in the same data/mod encoding the serializer accepts, so a serializer -> deserializer loopback round-trips.

Parameters:
- WIDTH, 16, parallel word width; must be a power of two ≥ 4.
- MIN_LEN, 3, shortest frame forwarded; shorter frames are dropped (the serializer never sends mod 1 or 2).

Ports:
- clk_i  input  1  clock
- srst_i  input  1  synchronous active-high reset
- data_i  input  1  serial data bit; sampled only when data_val_i=1
- data_val_i  input  1  serial bit valid; a run of 1s forms one frame
- deser_data_o  output  WIDTH  reassembled word; first received bit at [WIDTH-1]; unreceived low bits are 0
- deser_mod_o  output  $clog2(WIDTH)  bits in frame; WIDTH is encoded as 0
- deser_data_val_o  output  1  one-cycle pulse, word/mod valid
- drop_o  output  1  one-cycle pulse, runt frame (< MIN_LEN bits) discarded
- busy_o  output  1  1 while a frame is partially collected (bit count > 0)

Behaviour:
- Clock and reset: one clock, clk_i. srst_i is synchronous and active-high.
- Reset values: all outputs 0. Shift register, bit count and FSM are cleared.
- srst_i mid-frame: the partial frame is discarded with no val and no drop pulse. An input bit sampled in the reset cycle is ignored.
- FSM states:
  - IDLE: count=0. On data_val_i=1, load the bit into position WIDTH-1, set count=1 and go to COLLECT.
  - COLLECT, data_val_i=1: write the bit at position WIDTH-1-count and increment count.
    - If this is bit number WIDTH, emit immediately: the word includes this bit, mod=0. Count returns to 0, next state IDLE.
  - COLLECT, data_val_i=0: frame end.
    - count ≥ MIN_LEN: emit with mod=count.
    - Otherwise: pulse drop_o instead.
    - Clear the shift register and count; go to IDLE.
- Latency: outputs are registered. The val or drop pulse is high in the cycle after the clock edge where the ending condition was sampled.
  - Full frame: 1 cycle after the WIDTH-th bit.
  - Short frame: 1 cycle after the first data_val_i=0.
- Output hold: deser_data_o and deser_mod_o hold their last emitted value until the next emit. The implementation must not zero them after a drop.
- Back-to-back frames:
  - After a full-WIDTH emit, a data_val_i=1 in the very next cycle starts a new frame with no gap lost.
  - A short frame needs at least one data_val_i=0 cycle as delimiter; the first bit of the next frame can arrive in the cycle right after that gap.
- busy_o: combinational from count (count != 0). It is 0 in the cycle of a full-WIDTH emit, once count has cleared.
- No backpressure: the downstream stage must accept every pulse.

Decomposition:
- Shared package ser_pkg holds:
  - WIDTH default and MOD_W = $clog2(WIDTH)
  - typedef of the word type and the mod type
  - a mod-to-bit-count helper function (0 -> WIDTH), shared with the serializer and the benches
- No sub-module. The FSM, shift register and counter stay in one file, roughly 120–180 lines.

Test Plan:
- Reset, then 16 consecutive valid bits of 0xA5C3 MSB-first -> one pulse with deser_data_o=0xA5C3 and deser_mod_o=0, 1 cycle after the last bit; busy_o=1 during bits 2–16.
- 5 bits 1,0,1,1,0, then val=0 -> deser_data_o=0xB000, deser_mod_o=5, pulse 1 cycle after val falls.
- 2 valid bits, then gap -> drop_o pulse, no deser_data_val_o, deser_data_o keeps the previous word.
- Two 16-bit frames back-to-back with no gap (0xFFFF then 0x0001) -> two pulses exactly 16 cycles apart, correct words.
- srst_i asserted after 7 of 12 bits -> no pulse; the following 12-bit frame 0x123 decodes to deser_data_o=0x1230, deser_mod_o=12.
- Loopback with serializer: 1000 random data/mod pairs -> every word sent with mod ∉ {1,2} is reproduced in order, masked to mod bits.
